// File: rtl/clk_en_gen_pkg.sv
// Shared types and reset constants for the fractional clock-enable generator.
package clk_en_gen_pkg;

    localparam int PKG_INT_W    = 16;
    localparam int PKG_FRAC_W   = 8;
    localparam int DEF_INT_RST  = 288;
    localparam int DEF_FRAC_RST = 0;
    localparam int TICK_W       = 16;

    typedef struct packed {
        logic [PKG_INT_W-1:0]  div_int;
        logic [PKG_FRAC_W-1:0] div_frac;
        logic                  run;
    } div_cfg_t;

endpackage

// File: rtl/clk_en_gen_ch.sv
// One fractional clock-enable channel: period counter, phase accumulator and shadowed divisor.
// Optional pulse counter enabled by CLK_EN_GEN_TICK_CNT_EN.
module clk_en_gen_ch
    import clk_en_gen_pkg::*;
#(
    parameter int INT_W    = PKG_INT_W,
    parameter int FRAC_W   = PKG_FRAC_W,
    parameter int DEF_INT  = DEF_INT_RST,
    parameter int DEF_FRAC = DEF_FRAC_RST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_run,
    input  logic              sync_restart,
    output logic              pending,
    output logic              clk_en
`ifdef CLK_EN_GEN_TICK_CNT_EN
    ,
    output logic [TICK_W-1:0] tick_cnt
`endif
);

    logic [INT_W-1:0]  cnt;
    logic [INT_W-1:0]  act_int;
    logic [INT_W-1:0]  sh_int;
    logic [INT_W-1:0]  eff_int;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W-1:0] act_frac;
    logic [FRAC_W-1:0] sh_frac;
    logic              act_run;
    logic              sh_run;
    logic              carry;
    logic              terminal;
    logic [FRAC_W:0]   acc_sum;
    logic [INT_W:0]    last;

    // acc only changes at terminal count, so the carry (and hence P) is fixed for the whole period
    always_comb begin
        eff_int  = (act_int == '0) ? INT_W'(1) : act_int;
        acc_sum  = {1'b0, acc} + {1'b0, act_frac};
        carry    = acc_sum[FRAC_W];
        last     = {1'b0, eff_int} - (INT_W+1)'(1) + {{INT_W{1'b0}}, carry};
        terminal = act_run && ({1'b0, cnt} == last);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            act_int  <= INT_W'(DEF_INT);
            act_frac <= FRAC_W'(DEF_FRAC);
            act_run  <= 1'b1;
            sh_int   <= '0;
            sh_frac  <= '0;
            sh_run   <= 1'b0;
            pending  <= 1'b0;
            clk_en   <= 1'b0;
        end else if (sync_restart) begin
            cnt     <= '0;
            acc     <= '0;
            clk_en  <= 1'b0;
            pending <= 1'b0;
            if (cfg_wr) begin
                act_int  <= cfg_int;
                act_frac <= cfg_frac;
                act_run  <= cfg_run;
            end else if (pending) begin
                act_int  <= sh_int;
                act_frac <= sh_frac;
                act_run  <= sh_run;
            end
        end else if (cfg_wr && !act_run) begin
            act_int  <= cfg_int;
            act_frac <= cfg_frac;
            act_run  <= cfg_run;
            cnt      <= '0;
            acc      <= '0;
            clk_en   <= 1'b0;
        end else begin
            clk_en <= terminal;
            if (cfg_wr) begin
                sh_int  <= cfg_int;
                sh_frac <= cfg_frac;
                sh_run  <= cfg_run;
                pending <= 1'b1;
            end
            if (!act_run) begin
                cnt <= '0;
                acc <= '0;
            end else if (terminal) begin
                cnt <= '0;
                acc <= acc_sum[FRAC_W-1:0];
                // cfg_wr is gated by !pending upstream, so these never collide
                if (pending) begin
                    act_int  <= sh_int;
                    act_frac <= sh_frac;
                    act_run  <= sh_run;
                    pending  <= 1'b0;
                end
            end else begin
                cnt <= cnt + INT_W'(1);
            end
        end
    end

`ifdef CLK_EN_GEN_TICK_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (sync_restart) begin
            tick_cnt <= '0;
        end else if (clk_en) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with shared config port.
// Define CLK_EN_GEN_TICK_CNT_EN to add per-channel pulse counters on tick_cnt.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int INT_W    = PKG_INT_W,
    parameter int FRAC_W   = PKG_FRAC_W,
    parameter int DEF_INT  = DEF_INT_RST,
    parameter int DEF_FRAC = DEF_FRAC_RST,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    input  logic              cfg_run,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] clk_en
`ifdef CLK_EN_GEN_TICK_CNT_EN
    ,
    output logic [NUM_CH*TICK_W-1:0] tick_cnt
`endif
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_wr;

    // Unmapped channel indices read as ready so the writer never stalls on them
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign cfg_wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clk_en_gen_ch #(
            .INT_W    (INT_W),
            .FRAC_W   (FRAC_W),
            .DEF_INT  (DEF_INT),
            .DEF_FRAC (DEF_FRAC)
        ) u_ch (
            .clk          (clk),
            .reset        (reset),
            .cfg_wr       (cfg_wr[g]),
            .cfg_int      (cfg_int),
            .cfg_frac     (cfg_frac),
            .cfg_run      (cfg_run),
            .sync_restart (sync_restart),
            .pending      (pending[g]),
            .clk_en       (clk_en[g])
`ifdef CLK_EN_GEN_TICK_CNT_EN
            ,
            .tick_cnt     (tick_cnt[g*TICK_W +: TICK_W])
`endif
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: table of divisor vectors plus hand-written corner sequences.
module tb_clk_en_gen;

    localparam int NUM_CH = 2;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              cfg_valid    = 1'b0;
    logic              cfg_ready;
    logic [0:0]        cfg_ch       = '0;
    logic [15:0]       cfg_int      = '0;
    logic [7:0]        cfg_frac     = '0;
    logic              cfg_run      = 1'b1;
    logic              sync_restart = 1'b0;
    logic [NUM_CH-1:0] clk_en;
`ifdef CLK_EN_GEN_TICK_CNT_EN
    logic [NUM_CH*16-1:0] tick_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int npos;
    int pos[16];

    typedef struct {
        int ch;
        int div_i;
        int div_f;
        bit run;
        int ncyc;
        int exp_hi;
        int exp_first;
    } vec_t;

    vec_t vecs[8];

    clk_en_gen u_dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_int      (cfg_int),
        .cfg_frac     (cfg_frac),
        .cfg_run      (cfg_run),
        .sync_restart (sync_restart),
        .clk_en       (clk_en)
`ifdef CLK_EN_GEN_TICK_CNT_EN
        ,
        .tick_cnt     (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after an edge with reset released: cycle k=0
    task automatic do_reset();
        reset        = 1'b1;
        cfg_valid    = 1'b0;
        sync_restart = 1'b0;
        cfg_run      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Steps n cycles, recording the cycle numbers (k0+i) in which clk_en[ch] is high
    task automatic watch(input int ch, input int n, input int k0);
        npos = 0;
        for (int i = 0; i < 16; i++) pos[i] = -1;
        for (int i = 1; i <= n; i++) begin
            step();
            if (clk_en[ch]) begin
                if (npos < 16) pos[npos] = k0 + i;
                npos++;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 288,   0, 1'b1, 864,   3, 288};
        vecs[1] = '{1,   3, 128, 1'b1, 350, 100,   3};
        vecs[2] = '{0,   0,   0, 1'b1,  20,  20,   1};
        vecs[3] = '{1,   1,   0, 1'b1,  20,  20,   1};
        vecs[4] = '{0,  10,   0, 1'b1, 100,  10,  10};
        vecs[5] = '{1,   2,  64, 1'b1,  90,  40,   2};
        vecs[6] = '{0,   5, 255, 1'b1,  60,  10,   5};
        vecs[7] = '{1,   7,   0, 1'b0,  50,   0,  -1};

        // Reset values and default divide-by-288 cadence
        do_reset();
        cfg_ch = '0;
        #1;
        check("rst_clk_en", clk_en, 0);
        check("rst_ready", cfg_ready, 1);
`ifdef CLK_EN_GEN_TICK_CNT_EN
        check("rst_tick", tick_cnt, 0);
`endif
        watch(0, 900, 0);
        check("t1_pulses", npos, 3);
        for (int i = 0; i < 3; i++) check($sformatf("t1_pos%0d", i), pos[i], 288 * (i + 1));
`ifdef CLK_EN_GEN_TICK_CNT_EN
        check("t1_tick0", tick_cnt[15:0], 3);
`endif

        // Table: divisor applied immediately via same-cycle cfg accept + sync_restart
        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg_valid    = 1'b1;
            cfg_ch       = 1'(vecs[v].ch);
            cfg_int      = 16'(vecs[v].div_i);
            cfg_frac     = 8'(vecs[v].div_f);
            cfg_run      = vecs[v].run;
            sync_restart = 1'b1;
            step();
            cfg_valid    = 1'b0;
            sync_restart = 1'b0;
            cfg_run      = 1'b1;
            watch(vecs[v].ch, vecs[v].ncyc, 0);
            check($sformatf("vec%0d_hi", v), npos, vecs[v].exp_hi);
            check($sformatf("vec%0d_first", v), pos[0], vecs[v].exp_first);
        end

        // Mid-period write on a running channel, second write blocked until the boundary
        do_reset();
        repeat (100) step();
        cfg_valid = 1'b1;
        cfg_ch    = '0;
        cfg_int   = 16'd10;
        cfg_frac  = 8'd0;
        cfg_run   = 1'b1;
        #1;
        check("t3_ready_first", cfg_ready, 1);
        step();
        cfg_int = 16'd20;
        #1;
        check("t3_busy", cfg_ready, 0);
        cfg_valid = 1'b0;
        cfg_ch    = 1'b1;
        #1;
        check("t3_other_ready", cfg_ready, 1);
        cfg_ch = '0;
        watch(0, 219, 101);
        check("t3_pulses", npos, 4);
        check("t3_pos0", pos[0], 288);
        check("t3_pos1", pos[1], 298);
        check("t3_pos2", pos[2], 308);
        check("t3_pos3", pos[3], 318);
        check("t3_ready_back", cfg_ready, 1);

        // sync_restart on the terminal-count cycle
        do_reset();
        watch(0, 289, 0);
        check("t5_first_pulse", npos, 1);
`ifdef CLK_EN_GEN_TICK_CNT_EN
        check("t5_tick0_pre", tick_cnt[15:0], 1);
        check("t5_tick1_pre", tick_cnt[31:16], 1);
`endif
        repeat (286) step();
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check("t5_suppressed", clk_en, 0);
`ifdef CLK_EN_GEN_TICK_CNT_EN
        check("t5_tick_clr", tick_cnt, 0);
`endif
        repeat (287) step();
        check("t5_pre_edge", clk_en, 0);
        step();
        check("t5_together", clk_en, 3);
        step();
        check("t5_one_wide", clk_en, 0);

        // Async reset while a pulse is high and a write is pending
        do_reset();
        repeat (287) step();
        cfg_valid = 1'b1;
        cfg_ch    = '0;
        cfg_int   = 16'd5;
        cfg_frac  = 8'd0;
        cfg_run   = 1'b1;
        step();
        cfg_valid = 1'b0;
        #1;
        check("t6_pending", cfg_ready, 0);
        check("t6_pulse", clk_en[0], 1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_clk_en", clk_en, 0);
        check("t6_pend_drop", cfg_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        watch(0, 300, 0);
        check("t6_pulses", npos, 1);
        check("t6_default_pos", pos[0], 288);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
